// File: rtl/light_hash_pkg.sv
// Shared constants, FSM encoding and byte classifier for the light_hash_core
// byte-serial hash engine.
package light_hash_pkg;

    localparam int ROUNDS = 4;
    localparam int NBYTES = 8;

    localparam logic [7:0] IV [NBYTES] = '{
        8'h34, 8'h55, 8'h0F, 8'h14, 8'hAA, 8'h28, 8'h33, 8'h01
    };

    localparam logic [7:0] CODE_START = 8'hFF;
    localparam logic [7:0] CODE_END   = 8'h00;
    localparam logic [7:0] PRINT_LO   = 8'h20;
    localparam logic [7:0] PRINT_HI   = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ABSORB = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        BC_START   = 2'd0,
        BC_END     = 2'd1,
        BC_DATA    = 2'd2,
        BC_INVALID = 2'd3
    } byte_class_t;

    function automatic byte_class_t classify(input logic [7:0] b);
        if (b == CODE_START) begin
            return BC_START;
        end else if (b == CODE_END) begin
            return BC_END;
        end else if (b >= PRINT_LO && b <= PRINT_HI) begin
            return BC_DATA;
        end else begin
            return BC_INVALID;
        end
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: purely combinational 8-bit substitution.
module aes_sbox (
    input  logic [7:0] idx,
    output logic [7:0] sub
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign sub = SBOX[idx];

endmodule

// File: rtl/light_hash_core.sv
// Byte-serial 64-bit hash: framed byte stream absorbed one byte per clock
// through four unrolled S-box rounds; digest captured on the END code.
module light_hash_core
    import light_hash_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  message_byte,
    input  logic        message_valid,
    output logic [63:0] digest,
    output logic        digest_ready,
    output logic        err_invalid_message_byte,
    output logic [1:0]  dbg_state
);

    // Handshake: message_valid is a one-sided strobe with no ready/backpressure;
    // every rising edge with message_valid=1 consumes message_byte exactly once.

    state_t      state_q, state_d;
    byte_class_t byte_class;

    logic [7:0]  h_q    [NBYTES];
    logic [7:0]  h_next [NBYTES];
    logic [63:0] h_flat;
    logic [63:0] digest_q;
    logic        ready_q;
    logic        err_q;

    logic        load_iv;
    logic        absorb;
    logic        capture;
    logic        set_err;

    assign byte_class = classify(message_byte);

    // Round r feeds round r+1; round 0 reads the registered state.
    for (genvar r = 0; r < ROUNDS; r++) begin : g_round
        logic [7:0] h_in  [NBYTES];
        logic [7:0] h_out [NBYTES];

        if (r == 0) begin : g_first
            assign h_in = h_q;
        end else begin : g_chain
            assign h_in = g_round[r-1].h_out;
        end

        for (genvar i = 0; i < NBYTES; i++) begin : g_byte
            logic [7:0] s_out;

            aes_sbox u_sbox (
                .idx (h_in[(i + 2) % NBYTES] ^ message_byte ^ 8'(r)),
                .sub (s_out)
            );

            assign h_out[i] = s_out ^ rotl1(h_in[i]);
        end
    end

    assign h_next = g_round[ROUNDS-1].h_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (message_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (byte_class == BC_START) state_d = ST_ABSORB;
                end
                ST_ABSORB: begin
                    unique case (byte_class)
                        BC_START:   state_d = ST_ABSORB;
                        BC_END:     state_d = ST_DONE;
                        BC_INVALID: state_d = ST_ERROR;
                        default:    state_d = ST_ABSORB;
                    endcase
                end
                ST_DONE, ST_ERROR: begin
                    if (byte_class == BC_START) state_d = ST_ABSORB;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // START restarts from any state; everything else only acts inside a message.
    always_comb begin
        load_iv = 1'b0;
        absorb  = 1'b0;
        capture = 1'b0;
        set_err = 1'b0;
        if (message_valid) begin
            load_iv = (byte_class == BC_START);
            if (state_q == ST_ABSORB) begin
                absorb  = (byte_class == BC_DATA);
                capture = (byte_class == BC_END);
                set_err = (byte_class == BC_INVALID);
            end
        end
    end

    always_comb begin
        h_flat = '0;
        for (int i = 0; i < NBYTES; i++) begin
            h_flat[63 - 8*i -: 8] = h_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q      <= IV;
            digest_q <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (load_iv) begin
                h_q     <= IV;
                ready_q <= 1'b0;
                err_q   <= 1'b0;
            end else if (absorb) begin
                h_q <= h_next;
            end else if (capture) begin
                digest_q <= h_flat;
                ready_q  <= 1'b1;
            end else if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign digest                   = digest_q;
    assign digest_ready             = ready_q;
    assign err_invalid_message_byte = err_q;
    assign dbg_state                = state_q;

endmodule

// File: tb/tb_light_hash_core.sv
// Self-checking bench for light_hash_core: directed scenarios plus random
// framed streams, scored against a message-level reference hash.
module tb_light_hash_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  message_byte = 8'h00;
    logic        message_valid = 1'b0;
    logic [63:0] digest;
    logic        digest_ready;
    logic        err_invalid_message_byte;
    logic [1:0]  dbg_state;

    light_hash_core dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .message_byte             (message_byte),
        .message_valid            (message_valid),
        .digest                   (digest),
        .digest_ready             (digest_ready),
        .err_invalid_message_byte (err_invalid_message_byte),
        .dbg_state                (dbg_state)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] IV_WORD = 64'h34550F14AA283301;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  sbox_m [256];
    logic [7:0]  msg_q  [$];
    logic [63:0] exp_q  [$];
    logic        m_open;
    logic [63:0] m_digest;
    logic        m_ready;
    logic        m_err;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    // Reference S-box from its algebraic definition: GF(2^8) inverse + affine map.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [63:0] model_digest();
        logic [7:0] h [8];
        logic [7:0] t [8];
        for (int i = 0; i < 8; i++) h[i] = IV_WORD[63 - 8*i -: 8];
        foreach (msg_q[k]) begin
            for (int r = 0; r < 4; r++) begin
                for (int i = 0; i < 8; i++) begin
                    t[i] = sbox_m[h[(i + 2) % 8] ^ msg_q[k] ^ 8'(r)] ^ rotl8(h[i], 1);
                end
                h = t;
            end
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    // Message-level model: only "inside an open message" matters for DATA/END/INVALID.
    task automatic model_apply(input logic v, input logic [7:0] b);
        if (!v) return;
        if (b == 8'hFF) begin
            m_open = 1'b1;
            m_ready = 1'b0;
            m_err = 1'b0;
            msg_q.delete();
        end else if (!m_open) begin
            return;
        end else if (b == 8'h00) begin
            m_digest = model_digest();
            m_ready = 1'b1;
            m_open = 1'b0;
            exp_q.push_back(m_digest);
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            msg_q.push_back(b);
        end else begin
            m_err = 1'b1;
            m_open = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check_val("digest", digest, m_digest);
        check_val("digest_ready", 64'(digest_ready), 64'(m_ready));
        check_val("err", 64'(err_invalid_message_byte), 64'(m_err));
        while (exp_q.size() > 0) check_val("digest_at_end", digest, exp_q.pop_front());
    endtask

    task automatic step(input logic v, input logic [7:0] b);
        @(negedge clk);
        message_valid = v;
        message_byte  = b;
        @(posedge clk);
        model_apply(v, b);
        #1;
        check_outputs();
    endtask

    task automatic send(input logic [7:0] b, input int gap_lo, input int gap_hi);
        step(1'b1, b);
        repeat ($urandom_range(gap_hi, gap_lo)) step(1'b0, 8'($urandom_range(255, 0)));
    endtask

    task automatic send_str(input string s, input int gap_lo, input int gap_hi);
        for (int i = 0; i < s.len(); i++) send(s[i], gap_lo, gap_hi);
    endtask

    task automatic send_msg(input string s, input int gap_lo, input int gap_hi);
        send(8'hFF, gap_lo, gap_hi);
        send_str(s, gap_lo, gap_hi);
        send(8'h00, gap_lo, gap_hi);
    endtask

    // A START is driven during reset to show reset wins over a valid byte.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        message_valid = 1'b1;
        message_byte  = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        m_open = 1'b0;
        m_digest = '0;
        m_ready = 1'b0;
        m_err = 1'b0;
        msg_q.delete();
        exp_q.delete();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        message_valid = 1'b0;
    endtask

    function automatic logic [7:0] rand_byte();
        int sel = int'($urandom_range(99, 0));
        int v;
        if (sel < 80) return 8'($urandom_range(8'h7E, 8'h20));
        if (sel < 88) begin
            v = int'($urandom_range(158, 0));
            return (v < 31) ? 8'(v + 1) : 8'(8'h7F + v - 31);
        end
        if (sel < 94) return 8'hFF;
        return 8'h00;
    endfunction

    initial begin
        build_sbox();
        do_reset();

        send_str("ab", 0, 1);

        send(8'hFF, 0, 0);
        send(8'h00, 0, 0);
        check_val("empty_msg_iv", digest, IV_WORD);

        send_msg("a", 1, 3);
        send_msg("H4rdw4r3_Tr0j4n", 1, 3);
        send_msg("a", 0, 0);
        send_msg("H4rdw4r3_Tr0j4n", 0, 0);

        send(8'hFF, 0, 1);
        send_str("abc", 0, 1);
        send(8'h09, 0, 1);
        send_str("def", 0, 1);
        send(8'h00, 0, 1);
        send(8'h00, 0, 1);
        send_msg("recover", 0, 2);

        send(8'hFF, 0, 1);
        send_str("xyz", 0, 1);
        send_msg("AlessandroAndGiacomo", 0, 1);
        send_str("after", 0, 2);
        send(8'h00, 0, 1);

        send(8'hFF, 0, 0);
        send_str("abc", 0, 0);
        do_reset();
        send_msg("3.141592653589793238", 0, 2);

        for (int m = 0; m < 30; m++) begin
            int len = int'($urandom_range(12, 0));
            send(8'hFF, 0, 2);
            for (int j = 0; j < len; j++) send(rand_byte(), 0, 2);
            send(8'h00, 0, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
